// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: state encoding,
// opcode values, ALUOp and PCSrc codes, and the opcode legality check.
// Build option: MIPS_CTRL_ADDI_EN adds the ADDIEXEC/ADDIWB path for addi.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9
`ifdef MIPS_CTRL_ADDI_EN
      ,
      ADDIEXEC = 4'd10,
      ADDIWB   = 4'd11
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // True when the controller has a path for this opcode.
   function automatic logic isSupported(input logic [5:0] op);
      logic ok;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
`ifdef MIPS_CTRL_ADDI_EN
         OP_ADDI: ok = 1'b1;
`endif
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM whose datapath controls are
// decoded from the state register alone; ILLEGAL is the one Mealy output
// (DECODE cycle with an unsupported OPCODE).
// Build option: MIPS_CTRL_ADDI_EN enables the addi path; without it opcode
// 001000 is illegal.
// Handshake note: there is no valid/ready traffic here; OPCODE is taken as
// valid in every DECODE cycle and is ignored in all other states.
module mips_mc_controller
   import mips_ctrl_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] OPCODE,
   output logic       PCWriteCond,
   output logic       PCWrite,
   output logic       IorD,
   output logic       R_wbar,
   output logic       MemToReg,
   output logic       IRWrite,
   output logic       ALUSrcA,
   output logic       RegWrite,
   output logic       RegDst,
   output logic [1:0] PCSrc,
   output logic [1:0] ALUOp,
   output logic [1:0] ALUSrcB,
   output logic       ILLEGAL,
   output state_t     stateDbg
);

   state_t     state;
   state_t     nextState;
   logic [5:0] opReg;

   // State register; opcode is captured in DECODE so MEMADR can split lw/sw.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= FETCH;
         opReg <= OP_RTYPE;
      end else begin
         state <= nextState;
         if (state == DECODE) opReg <= OPCODE;
      end
   end

   // Next-state selection.
   always_comb begin
      nextState = FETCH;
      case (state)
         FETCH:  nextState = DECODE;
         DECODE: begin
            case (OPCODE)
               OP_LW, OP_SW: nextState = MEMADR;
               OP_RTYPE:     nextState = EXEC;
               OP_BEQ:       nextState = BRANCH;
               OP_J:         nextState = JUMP;
`ifdef MIPS_CTRL_ADDI_EN
               OP_ADDI:      nextState = ADDIEXEC;
`endif
               default:      nextState = FETCH;
            endcase
         end
         MEMADR: nextState = (opReg == OP_LW) ? MEMRD : MEMWR;
         MEMRD:  nextState = MEMWB;
         EXEC:   nextState = ALUWB;
`ifdef MIPS_CTRL_ADDI_EN
         ADDIEXEC: nextState = ADDIWB;
`endif
         default: nextState = FETCH;
      endcase
   end

   // Output decode from the state register; R_wbar idles high (read).
   always_comb begin
      PCWriteCond = 1'b0;
      PCWrite     = 1'b0;
      IorD        = 1'b0;
      R_wbar      = 1'b1;
      MemToReg    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      PCSrc       = PCSRC_ALU;
      ALUOp       = ALUOP_ADD;
      ALUSrcB     = 2'b00;
      case (state)
         FETCH: begin
            IRWrite = 1'b1;
            ALUSrcB = 2'b01;
            PCWrite = 1'b1;
         end
         DECODE: ALUSrcB = 2'b11;
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         MEMRD: IorD = 1'b1;
         MEMWB: begin
            MemToReg = 1'b1;
            RegWrite = 1'b1;
         end
         MEMWR: begin
            IorD   = 1'b1;
            R_wbar = 1'b0;
         end
         EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
         end
         ALUWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCSrc       = PCSRC_ALUOUT;
            PCWriteCond = 1'b1;
         end
         JUMP: begin
            PCSrc   = PCSRC_JUMP;
            PCWrite = 1'b1;
         end
`ifdef MIPS_CTRL_ADDI_EN
         ADDIEXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         ADDIWB: RegWrite = 1'b1;
`endif
         default: ;
      endcase
   end

   // Mealy flag: current DECODE cycle sees an opcode with no path.
   always_comb begin
      ILLEGAL = (state == DECODE) && !isSupported(OPCODE);
   end

   assign stateDbg = state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: each instruction is expanded
// into its expected per-cycle control words from the instruction-level
// description, queued, and compared against the DUT on every falling edge.
module tb_mips_mc_controller;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [5:0] OPCODE = 6'd0;
   logic       PCWriteCond, PCWrite, IorD, R_wbar, MemToReg, IRWrite;
   logic       ALUSrcA, RegWrite, RegDst, ILLEGAL;
   logic [1:0] PCSrc, ALUOp, ALUSrcB;
   mips_ctrl_pkg::state_t stateDbg;

   int checks = 0;
   int passes = 0;
   logic [15:0] exp_q[$];

   mips_mc_controller dut (
      .CLK(CLK), .RST(RST), .OPCODE(OPCODE),
      .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
      .R_wbar(R_wbar), .MemToReg(MemToReg), .IRWrite(IRWrite),
      .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
      .PCSrc(PCSrc), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
      .ILLEGAL(ILLEGAL), .stateDbg(stateDbg)
   );

   // Clock and reset block
   always #5 CLK = ~CLK;

   // Control word layout (bit 15 down to 0):
   // PCWriteCond PCWrite IorD R_wbar MemToReg IRWrite ALUSrcA RegWrite RegDst
   // PCSrc[1:0] ALUOp[1:0] ALUSrcB[1:0] ILLEGAL
   function automatic logic [15:0] mk(input bit pcwc, pcw, iord, rw, mtr, irw,
                                      asa, regw, rdst, input bit [1:0] pcsrc,
                                      aluop, asb, input bit ill);
      return {pcwc, pcw, iord, rw, mtr, irw, asa, regw, rdst, pcsrc, aluop, asb, ill};
   endfunction

   function automatic bit legal_op(input logic [5:0] op);
      bit ok;
      ok = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
           (op == 6'b000100) || (op == 6'b000010);
`ifdef MIPS_CTRL_ADDI_EN
      if (op == 6'b001000) ok = 1'b1;
`endif
      return ok;
   endfunction

   // Reference model: expected control words, cycle by cycle, for one instruction
   task automatic plan(input logic [5:0] op, output logic [15:0] seq[5], output int n);
      logic [15:0] fetchW, decW;
      fetchW = mk(0,1,0,1,0,1,0,0,0, 2'b00,2'b00,2'b01, 0);
      decW   = mk(0,0,0,1,0,0,0,0,0, 2'b00,2'b00,2'b11, !legal_op(op));
      for (int i = 0; i < 5; i++) seq[i] = 16'h0;
      seq[0] = fetchW;
      seq[1] = decW;
      n = 2;
      if (op == 6'b100011) begin
         seq[2] = mk(0,0,0,1,0,0,1,0,0, 2'b00,2'b00,2'b10, 0);
         seq[3] = mk(0,0,1,1,0,0,0,0,0, 2'b00,2'b00,2'b00, 0);
         seq[4] = mk(0,0,0,1,1,0,0,1,0, 2'b00,2'b00,2'b00, 0);
         n = 5;
      end else if (op == 6'b101011) begin
         seq[2] = mk(0,0,0,1,0,0,1,0,0, 2'b00,2'b00,2'b10, 0);
         seq[3] = mk(0,0,1,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0);
         n = 4;
      end else if (op == 6'b000000) begin
         seq[2] = mk(0,0,0,1,0,0,1,0,0, 2'b00,2'b10,2'b00, 0);
         seq[3] = mk(0,0,0,1,0,0,0,1,1, 2'b00,2'b00,2'b00, 0);
         n = 4;
      end else if (op == 6'b000100) begin
         seq[2] = mk(1,0,0,1,0,0,1,0,0, 2'b01,2'b01,2'b00, 0);
         n = 3;
      end else if (op == 6'b000010) begin
         seq[2] = mk(0,1,0,1,0,0,0,0,0, 2'b10,2'b00,2'b00, 0);
         n = 3;
      end else if (op == 6'b001000 && legal_op(op)) begin
         seq[2] = mk(0,0,0,1,0,0,1,0,0, 2'b00,2'b00,2'b10, 0);
         seq[3] = mk(0,0,0,1,0,0,0,1,0, 2'b00,2'b00,2'b00, 0);
         n = 4;
      end
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h (state %0d) at %0t", name, act, exp, stateDbg, $time);
   endtask

   // Driver: run one instruction, optionally raising RST during cycle rstAt
   task automatic run_instr(input logic [5:0] op, input int rstAt);
      logic [15:0] seq[5];
      int n;
      plan(op, seq, n);
      if (rstAt >= 0 && rstAt < n) n = rstAt + 1;
      for (int c = 0; c < n; c++) begin
         @(posedge CLK);
         #1;
         OPCODE = (c == 1) ? op : 6'($urandom_range(0, 63));
         RST    = (c == rstAt);
         exp_q.push_back(seq[c]);
      end
   endtask

   // Scoreboard: compare every cycle that has an expected word
   always @(negedge CLK) begin
      logic [15:0] act, exp;
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         act = {PCWriteCond, PCWrite, IorD, R_wbar, MemToReg, IRWrite, ALUSrcA,
                RegWrite, RegDst, PCSrc, ALUOp, ALUSrcB, ILLEGAL};
         check("ctrl", act, exp);
         check("memwr_vs_regwrite", {15'd0, (!R_wbar && RegWrite)}, 16'd0);
         check("pcwrite_vs_cond", {15'd0, (PCWrite && PCWriteCond)}, 16'd0);
      end
   end

   initial begin
      logic [15:0] seq[5];
      int n;
      logic [5:0] op;
      int rstAt;
      int wait_cnt;

      // Pin the model with hand-computed words
      plan(6'b100011, seq, n);
      check("pin_lw_latency", 16'(n), 16'd5);
      check("pin_fetch_word", seq[0], 16'h5402);
      check("pin_memwb_word", seq[4], 16'h1900);
      plan(6'b101011, seq, n);
      check("pin_sw_latency", 16'(n), 16'd4);
      check("pin_memwr_word", seq[3], 16'h2000);
      plan(6'b000100, seq, n);
      check("pin_beq_latency", 16'(n), 16'd3);
      check("pin_branch_word", seq[2], 16'h9228);
      plan(6'b000010, seq, n);
      check("pin_jump_word", seq[2], 16'h5040);
      plan(6'b111111, seq, n);
      check("pin_illegal_latency", 16'(n), 16'd2);
      check("pin_illegal_decode", seq[1], 16'h1007);

      // Reset: held for two edges, outputs must show FETCH while RST is high
      RST = 1'b1;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      exp_q.push_back(16'h5402);

      // Directed instructions
      run_instr(6'b100011, -1);   // lw
      run_instr(6'b101011, -1);   // sw
      run_instr(6'b000100, -1);   // beq
      run_instr(6'b000010, -1);   // j
      run_instr(6'b111111, -1);   // illegal
      run_instr(6'b001000, -1);   // addi (illegal unless enabled)
      run_instr(6'b000000, 2);    // R-type, reset in EXEC cycle
      run_instr(6'b000000, -1);   // R-type full

      // Random instruction stream with occasional mid-instruction reset
      for (int k = 0; k < 120; k++) begin
         case ($urandom_range(0, 7))
            0: op = 6'b100011;
            1: op = 6'b101011;
            2: op = 6'b000000;
            3: op = 6'b000100;
            4: op = 6'b000010;
            5: op = 6'b001000;
            default: op = 6'($urandom_range(0, 63));
         endcase
         rstAt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
         run_instr(op, rstAt);
      end

      wait_cnt = 0;
      while (exp_q.size() > 0 && wait_cnt < 10) begin
         @(posedge CLK);
         wait_cnt++;
      end
      @(posedge CLK);
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain: %0d expected words left, 0 required", exp_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
